// File: rtl/id_stage_pkg.sv
// Shared RV32I/M decode types: opcodes, funct3 encodings, mux selects and the
// control word carried across the ID/EX boundary.
package id_stage_pkg;

   typedef enum logic [6:0] {
      op_lui   = 7'b0110111,
      op_auipc = 7'b0010111,
      op_jal   = 7'b1101111,
      op_jalr  = 7'b1100111,
      op_br    = 7'b1100011,
      op_load  = 7'b0000011,
      op_store = 7'b0100011,
      op_imm   = 7'b0010011,
      op_reg   = 7'b0110011,
      op_csr   = 7'b1110011
   } rv32i_opcode;

   typedef enum logic [2:0] {
      beq  = 3'b000,
      bne  = 3'b001,
      blt  = 3'b100,
      bge  = 3'b101,
      bltu = 3'b110,
      bgeu = 3'b111
   } branch_funct3_t;

   typedef enum logic [2:0] {
      lb  = 3'b000,
      lh  = 3'b001,
      lw  = 3'b010,
      lbu = 3'b100,
      lhu = 3'b101
   } load_funct3_t;

   typedef enum logic [2:0] {
      sb = 3'b000,
      sh = 3'b001,
      sw = 3'b010
   } store_funct3_t;

   typedef enum logic [2:0] {
      add  = 3'b000,
      sll  = 3'b001,
      slt  = 3'b010,
      sltu = 3'b011,
      axor = 3'b100,
      sr   = 3'b101,
      aor  = 3'b110,
      aand = 3'b111
   } arith_funct3_t;

   typedef enum logic [2:0] {
      mul    = 3'b000,
      mulh   = 3'b001,
      mulhsu = 3'b010,
      mulhu  = 3'b011,
      div    = 3'b100,
      divu   = 3'b101,
      rem    = 3'b110,
      remu   = 3'b111
   } muldiv_funct3_t;

   // Chosen so that add/sll/xor/srl/or/and coincide with their funct3 values.
   typedef enum logic [2:0] {
      alu_add = 3'b000,
      alu_sll = 3'b001,
      alu_sra = 3'b010,
      alu_sub = 3'b011,
      alu_xor = 3'b100,
      alu_srl = 3'b101,
      alu_or  = 3'b110,
      alu_and = 3'b111
   } alu_ops;

   typedef enum logic {
      am1_rs1_out = 1'b0,
      am1_pc_out  = 1'b1
   } alumux1_sel_t;

   typedef enum logic [2:0] {
      am2_i_imm   = 3'd0,
      am2_u_imm   = 3'd1,
      am2_b_imm   = 3'd2,
      am2_s_imm   = 3'd3,
      am2_j_imm   = 3'd4,
      am2_rs2_out = 3'd5
   } alumux2_sel_t;

   typedef enum logic {
      cm_rs2_out = 1'b0,
      cm_i_imm   = 1'b1
   } cmpmux_sel_t;

   typedef enum logic [3:0] {
      rf_alu_out    = 4'd0,
      rf_br_en      = 4'd1,
      rf_u_imm      = 4'd2,
      rf_lw         = 4'd3,
      rf_pc_plus4   = 4'd4,
      rf_lb         = 4'd5,
      rf_lbu        = 4'd6,
      rf_lh         = 4'd7,
      rf_lhu        = 4'd8,
      rf_muldiv_out = 4'd9
   } regfilemux_sel_t;

   typedef enum logic [1:0] {
      pcm_pc_plus4 = 2'd0,
      pcm_alu_out  = 2'd1,
      pcm_alu_mod2 = 2'd2
   } pcmux_sel_t;

   typedef struct packed {
      alu_ops          aluop;
      branch_funct3_t  cmpop;
      alumux1_sel_t    alumux1_sel;
      alumux2_sel_t    alumux2_sel;
      cmpmux_sel_t     cmpmux_sel;
      regfilemux_sel_t regfilemux_sel;
      pcmux_sel_t      pcmux_sel;
      logic            load_regfile;
      logic            dmem_read;
      logic            dmem_write;
      logic [3:0]      mem_byte_enable;
      logic            muldiv_en;
      muldiv_funct3_t  muldiv_op;
   } rv32i_control_word;

   localparam logic [6:0] RV32M_FUNCT7 = 7'b0000001;
   localparam logic [6:0] BASE_FUNCT7  = 7'b0000000;
   localparam logic [6:0] ALT_FUNCT7   = 7'b0100000;

   function automatic rv32i_control_word default_ctrl();
      rv32i_control_word c;
      c.aluop           = alu_add;
      c.cmpop           = beq;
      c.alumux1_sel     = am1_rs1_out;
      c.alumux2_sel     = am2_i_imm;
      c.cmpmux_sel      = cm_rs2_out;
      c.regfilemux_sel  = rf_alu_out;
      c.pcmux_sel       = pcm_pc_plus4;
      c.load_regfile    = 1'b0;
      c.dmem_read       = 1'b0;
      c.dmem_write      = 1'b0;
      c.mem_byte_enable = 4'b1111;
      c.muldiv_en       = 1'b0;
      c.muldiv_op       = mul;
      return c;
   endfunction

endpackage

// File: rtl/id_stage_decode_rom.sv
// Combinational RV32I (+ optional RV32M) decoder: instruction word to control
// word, illegal flag, register-field extraction and source-usage flags.
module decode_rom
   import id_stage_pkg::*;
#(
   parameter bit ENABLE_M = 1'b1
) (
   input  logic [31:0]       instr,
   output rv32i_control_word ctrl,
   output logic              illegal,
   output logic              rs1_used,
   output logic              rs2_used,
   output logic [4:0]        rs1_addr,
   output logic [4:0]        rs2_addr,
   output logic [4:0]        rd_addr
);

   logic [2:0]  funct3;
   logic [6:0]  funct7;
   rv32i_opcode opcode;

   assign funct3   = instr[14:12];
   assign funct7   = instr[31:25];
   assign opcode   = rv32i_opcode'(instr[6:0]);
   assign rs1_addr = instr[19:15];
   assign rs2_addr = instr[24:20];
   assign rd_addr  = instr[11:7];

   always_comb begin
      ctrl     = default_ctrl();
      illegal  = 1'b0;
      rs1_used = 1'b0;
      rs2_used = 1'b0;

      case (opcode)
         op_lui: begin
            ctrl.load_regfile   = 1'b1;
            ctrl.regfilemux_sel = rf_u_imm;
         end
         op_auipc: begin
            ctrl.alumux1_sel  = am1_pc_out;
            ctrl.alumux2_sel  = am2_u_imm;
            ctrl.load_regfile = 1'b1;
         end
         op_jal: begin
            ctrl.alumux1_sel    = am1_pc_out;
            ctrl.alumux2_sel    = am2_j_imm;
            ctrl.pcmux_sel      = pcm_alu_mod2;
            ctrl.regfilemux_sel = rf_pc_plus4;
            ctrl.load_regfile   = 1'b1;
         end
         op_jalr: begin
            rs1_used            = 1'b1;
            ctrl.alumux2_sel    = am2_i_imm;
            ctrl.pcmux_sel      = pcm_alu_mod2;
            ctrl.regfilemux_sel = rf_pc_plus4;
            ctrl.load_regfile   = 1'b1;
            illegal             = (funct3 != 3'b000);
         end
         op_br: begin
            rs1_used         = 1'b1;
            rs2_used         = 1'b1;
            ctrl.alumux1_sel = am1_pc_out;
            ctrl.alumux2_sel = am2_b_imm;
            ctrl.cmpop       = branch_funct3_t'(funct3);
            illegal          = (funct3 == 3'b010) || (funct3 == 3'b011);
         end
         op_load: begin
            rs1_used          = 1'b1;
            ctrl.alumux2_sel  = am2_i_imm;
            ctrl.dmem_read    = 1'b1;
            ctrl.load_regfile = 1'b1;
            case (funct3)
               3'b000:  ctrl.regfilemux_sel = rf_lb;
               3'b001:  ctrl.regfilemux_sel = rf_lh;
               3'b010:  ctrl.regfilemux_sel = rf_lw;
               3'b100:  ctrl.regfilemux_sel = rf_lbu;
               3'b101:  ctrl.regfilemux_sel = rf_lhu;
               default: illegal = 1'b1;
            endcase
         end
         op_store: begin
            rs1_used         = 1'b1;
            rs2_used         = 1'b1;
            ctrl.alumux2_sel = am2_s_imm;
            ctrl.dmem_write  = 1'b1;
            case (funct3)
               3'b000:  ctrl.mem_byte_enable = 4'b0001;
               3'b001:  ctrl.mem_byte_enable = 4'b0011;
               3'b010:  ctrl.mem_byte_enable = 4'b1111;
               default: illegal = 1'b1;
            endcase
         end
         op_imm: begin
            rs1_used          = 1'b1;
            ctrl.alumux2_sel  = am2_i_imm;
            ctrl.load_regfile = 1'b1;
            case (funct3)
               3'b010: begin
                  ctrl.cmpop          = blt;
                  ctrl.cmpmux_sel     = cm_i_imm;
                  ctrl.regfilemux_sel = rf_br_en;
               end
               3'b011: begin
                  ctrl.cmpop          = bltu;
                  ctrl.cmpmux_sel     = cm_i_imm;
                  ctrl.regfilemux_sel = rf_br_en;
               end
               3'b001: begin
                  ctrl.aluop = alu_sll;
                  illegal    = (funct7 != BASE_FUNCT7);
               end
               3'b101: begin
                  if (funct7 == BASE_FUNCT7)     ctrl.aluop = alu_srl;
                  else if (funct7 == ALT_FUNCT7) ctrl.aluop = alu_sra;
                  else                           illegal    = 1'b1;
               end
               default: ctrl.aluop = alu_ops'(funct3);
            endcase
         end
         op_reg: begin
            rs1_used          = 1'b1;
            rs2_used          = 1'b1;
            ctrl.alumux2_sel  = am2_rs2_out;
            ctrl.load_regfile = 1'b1;
            if (ENABLE_M && (funct7 == RV32M_FUNCT7)) begin
               ctrl.muldiv_en      = 1'b1;
               ctrl.muldiv_op      = muldiv_funct3_t'(funct3);
               ctrl.regfilemux_sel = rf_muldiv_out;
            end else if (funct7 == BASE_FUNCT7) begin
               case (funct3)
                  3'b010: begin
                     ctrl.cmpop          = blt;
                     ctrl.regfilemux_sel = rf_br_en;
                  end
                  3'b011: begin
                     ctrl.cmpop          = bltu;
                     ctrl.regfilemux_sel = rf_br_en;
                  end
                  default: ctrl.aluop = alu_ops'(funct3);
               endcase
            end else if (funct7 == ALT_FUNCT7) begin
               case (funct3)
                  3'b000:  ctrl.aluop = alu_sub;
                  3'b101:  ctrl.aluop = alu_sra;
                  default: illegal = 1'b1;
               endcase
            end else begin
               illegal = 1'b1;
            end
         end
         default: illegal = 1'b1;
      endcase

      if (illegal) begin
         ctrl = default_ctrl();
      end
      // Writes to x0 are dropped here so EX and the hazard check never see them.
      if (rd_addr == 5'd0) begin
         ctrl.load_regfile = 1'b0;
      end
   end

endmodule

// File: rtl/id_stage.sv
// RV32I/M decode stage: load-use interlock, mul/div occupancy counter and the
// registered ID/EX boundary feeding execute.
module id_stage
   import id_stage_pkg::*;
#(
   parameter bit ENABLE_M   = 1'b1,
   parameter int MUL_CYCLES = 3,
   parameter int DIV_CYCLES = 33
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_valid,
   input  logic [31:0]       if_instr,
   input  logic [31:0]       if_pc,
   input  logic              stall_in,
   input  logic              flush,
   output logic              id_ready,
   output logic              ex_valid,
   output rv32i_control_word ex_ctrl,
   output logic [31:0]       ex_pc,
   output logic [31:0]       ex_instr,
   output logic [4:0]        ex_rd,
   output logic              ex_illegal,
   output logic              muldiv_busy
);

   localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   rv32i_control_word dec_ctrl;
   logic              dec_illegal;
   logic              rs1_used, rs2_used;
   logic [4:0]        rs1_addr, rs2_addr, rd_addr;

   decode_rom #(.ENABLE_M(ENABLE_M)) u_decode (
      .instr    (if_instr),
      .ctrl     (dec_ctrl),
      .illegal  (dec_illegal),
      .rs1_used (rs1_used),
      .rs2_used (rs2_used),
      .rs1_addr (rs1_addr),
      .rs2_addr (rs2_addr),
      .rd_addr  (rd_addr)
   );

   logic              ex_valid_q, ex_valid_d;
   rv32i_control_word ex_ctrl_q, ex_ctrl_d;
   logic [31:0]       ex_pc_q, ex_pc_d;
   logic [31:0]       ex_instr_q, ex_instr_d;
   logic [4:0]        ex_rd_q, ex_rd_d;
   logic              ex_illegal_q, ex_illegal_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              load_use;
   logic              src_match;

   assign src_match = (rs1_used && (rs1_addr == ex_rd_q)) ||
                      (rs2_used && (rs2_addr == ex_rd_q));
   assign load_use  = if_valid && ex_valid_q && ex_ctrl_q.dmem_read &&
                      (ex_rd_q != 5'd0) && src_match;

   always_comb begin
      ex_valid_d   = ex_valid_q;
      ex_ctrl_d    = ex_ctrl_q;
      ex_pc_d      = ex_pc_q;
      ex_instr_d   = ex_instr_q;
      ex_rd_d      = ex_rd_q;
      ex_illegal_d = ex_illegal_q;
      cnt_d        = cnt_q;
      id_ready     = 1'b0;

      if (flush) begin
         ex_valid_d = 1'b0;
         cnt_d      = '0;
      end else if (stall_in) begin
         cnt_d = cnt_q;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_ONE;
      end else if (load_use) begin
         ex_valid_d = 1'b0;
      end else begin
         id_ready     = 1'b1;
         ex_valid_d   = if_valid;
         ex_ctrl_d    = dec_ctrl;
         ex_pc_d      = if_pc;
         ex_instr_d   = if_instr;
         ex_rd_d      = dec_ctrl.load_regfile ? rd_addr : 5'd0;
         ex_illegal_d = dec_illegal;
         // funct3[2] separates the divide group from the multiply group.
         if (if_valid && dec_ctrl.muldiv_en) begin
            cnt_d = if_instr[14] ? DIV_LOAD : MUL_LOAD;
         end else begin
            cnt_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_q   <= 1'b0;
         ex_ctrl_q    <= default_ctrl();
         ex_pc_q      <= 32'd0;
         ex_instr_q   <= 32'd0;
         ex_rd_q      <= 5'd0;
         ex_illegal_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         ex_valid_q   <= ex_valid_d;
         ex_ctrl_q    <= ex_ctrl_d;
         ex_pc_q      <= ex_pc_d;
         ex_instr_q   <= ex_instr_d;
         ex_rd_q      <= ex_rd_d;
         ex_illegal_q <= ex_illegal_d;
         cnt_q        <= cnt_d;
      end
   end

   assign ex_valid    = ex_valid_q;
   assign ex_ctrl     = ex_ctrl_q;
   assign ex_pc       = ex_pc_q;
   assign ex_instr    = ex_instr_q;
   assign ex_rd       = ex_rd_q;
   assign ex_illegal  = ex_illegal_q;
   assign muldiv_busy = (cnt_q != '0);

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: instruction-class model with per-cycle compare, plus
// directed sequences with literal expectations.
module tb_id_stage;
   import id_stage_pkg::*;

   localparam int MUL_C = 3;
   localparam int DIV_C = 33;

   logic clk = 1'b0;
   logic rst, if_valid, stall_in, flush;
   logic [31:0] if_instr, if_pc;

   logic id_ready, ex_valid, ex_illegal, muldiv_busy;
   rv32i_control_word ex_ctrl;
   logic [31:0] ex_pc, ex_instr;
   logic [4:0]  ex_rd;

   logic n_ready, n_valid, n_illegal, n_busy;
   rv32i_control_word n_ctrl;
   logic [31:0] n_pc, n_instr;
   logic [4:0]  n_rd;

   int n_checks = 0;
   int n_errors = 0;
   logic go = 1'b0;

   always #5 clk = ~clk;

   id_stage #(.ENABLE_M(1'b1), .MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .stall_in(stall_in), .flush(flush), .id_ready(id_ready), .ex_valid(ex_valid),
      .ex_ctrl(ex_ctrl), .ex_pc(ex_pc), .ex_instr(ex_instr), .ex_rd(ex_rd),
      .ex_illegal(ex_illegal), .muldiv_busy(muldiv_busy)
   );

   id_stage #(.ENABLE_M(1'b0), .MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut_nom (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .stall_in(stall_in), .flush(flush), .id_ready(n_ready), .ex_valid(n_valid),
      .ex_ctrl(n_ctrl), .ex_pc(n_pc), .ex_instr(n_instr), .ex_rd(n_rd),
      .ex_illegal(n_illegal), .muldiv_busy(n_busy)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- instruction-class model ----------------
   typedef struct {
      logic       lr, dr, dw, md, ill, rs1u, rs2u;
      logic [4:0] rd;
      logic [2:0] alu;
      int         cyc;
   } exp_t;

   function automatic logic [2:0] arith_alu(input logic [2:0] f3);
      case (f3)
         3'd1:    return alu_sll;
         3'd4:    return alu_xor;
         3'd5:    return alu_srl;
         3'd6:    return alu_or;
         3'd7:    return alu_and;
         default: return alu_add;
      endcase
   endfunction

   function automatic exp_t mdec(input logic [31:0] i);
      exp_t e;
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
      e = '{default: 0};
      e.alu = alu_add;
      case (op)
         7'h37, 7'h17, 7'h6f: e.lr = 1;
         7'h67: begin e.lr = 1; e.rs1u = 1; e.ill = (f3 != 0); end
         7'h63: begin e.rs1u = 1; e.rs2u = 1; e.ill = (f3 == 2 || f3 == 3); end
         7'h03: begin e.rs1u = 1; e.lr = 1; e.dr = 1; e.ill = !(f3 inside {0, 1, 2, 4, 5}); end
         7'h23: begin e.rs1u = 1; e.rs2u = 1; e.dw = 1; e.ill = (f3 > 2); end
         7'h13: begin
            e.rs1u = 1; e.lr = 1; e.alu = arith_alu(f3);
            if (f3 == 1 && f7 != 0) e.ill = 1;
            if (f3 == 5) begin
               if (f7 == 7'h20) e.alu = alu_sra;
               else if (f7 != 0) e.ill = 1;
            end
         end
         7'h33: begin
            e.rs1u = 1; e.rs2u = 1; e.lr = 1;
            if (f7 == 7'h01) begin
               e.md = 1; e.cyc = f3[2] ? DIV_C : MUL_C;
            end else if (f7 == 7'h00) begin
               e.alu = arith_alu(f3);
            end else if (f7 == 7'h20 && f3 == 0) begin
               e.alu = alu_sub;
            end else if (f7 == 7'h20 && f3 == 5) begin
               e.alu = alu_sra;
            end else begin
               e.ill = 1;
            end
         end
         default: e.ill = 1;
      endcase
      if (e.ill) begin
         e.lr = 0; e.dr = 0; e.dw = 0; e.md = 0; e.cyc = 0; e.alu = alu_add;
      end
      if (i[11:7] == 5'd0) e.lr = 0;
      e.rd = e.lr ? i[11:7] : 5'd0;
      return e;
   endfunction

   exp_t m_e, dec_now;
   logic m_valid;
   logic [31:0] m_pc, m_instr;
   int m_cnt;
   logic exp_hz, exp_ready;

   always_comb begin
      dec_now = mdec(if_instr);
      exp_hz  = if_valid && m_valid && m_e.dr && (m_e.rd != 0) &&
                ((dec_now.rs1u && if_instr[19:15] == m_e.rd) ||
                 (dec_now.rs2u && if_instr[24:20] == m_e.rd));
      exp_ready = !flush && !stall_in && (m_cnt == 0) && !exp_hz;
   end

   always @(posedge clk) begin
      if (rst) begin
         m_valid <= 0; m_cnt <= 0; m_pc <= 0; m_instr <= 0;
         m_e <= '{default: 0};
      end else if (flush) begin
         m_valid <= 0; m_cnt <= 0;
      end else if (stall_in) begin
         m_cnt <= m_cnt;
      end else if (m_cnt != 0) begin
         m_cnt <= m_cnt - 1;
      end else if (exp_hz) begin
         m_valid <= 0;
      end else begin
         m_valid <= if_valid;
         m_pc    <= if_pc;
         m_instr <= if_instr;
         m_e     <= dec_now;
         m_cnt   <= (if_valid && dec_now.md) ? dec_now.cyc - 1 : 0;
      end
   end

   always @(negedge clk) begin
      if (go) begin
         chk("m_ex_valid", 32'(ex_valid), 32'(m_valid));
         chk("m_id_ready", 32'(id_ready), 32'(exp_ready));
         chk("m_busy", 32'(muldiv_busy), 32'(m_cnt != 0));
         chk("m_ex_pc", ex_pc, m_pc);
         chk("m_ex_instr", ex_instr, m_instr);
         if (m_valid) begin
            chk("m_ex_rd", 32'(ex_rd), 32'(m_e.rd));
            chk("m_illegal", 32'(ex_illegal), 32'(m_e.ill));
            chk("m_load_regfile", 32'(ex_ctrl.load_regfile), 32'(m_e.lr));
            chk("m_dmem_read", 32'(ex_ctrl.dmem_read), 32'(m_e.dr));
            chk("m_dmem_write", 32'(ex_ctrl.dmem_write), 32'(m_e.dw));
            chk("m_muldiv_en", 32'(ex_ctrl.muldiv_en), 32'(m_e.md));
            chk("m_aluop", 32'(ex_ctrl.aluop), 32'(m_e.alu));
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
      if_valid = 1'b1; if_instr = ins; if_pc = pc;
      #1;
      for (int k = 0; k < 60 && !id_ready; k++) step();
      if (!id_ready) begin
         n_errors++;
         $display("FAIL issue_timeout: id_ready got 0 expected 1 (pc %0h)", pc);
      end
      step();
   endtask

   localparam logic [31:0] I_LW    = 32'h0000A103;
   localparam logic [31:0] I_ADD   = 32'h001101B3;
   localparam logic [31:0] I_MUL   = 32'h02108233;
   localparam logic [31:0] I_DIV   = 32'h0210C2B3;
   localparam logic [31:0] I_ADDI  = 32'h00108093;

   logic [31:0] seq [9];

   initial begin
      seq[0] = 32'h123450B7;   // lui x1
      seq[1] = 32'h0020A223;   // sw x2,4(x1)
      seq[2] = 32'hFFFFFFFF;   // unknown opcode
      seq[3] = 32'h00208463;   // beq x1,x2
      seq[4] = 32'h4020D1B3;   // sra x3,x1,x2
      seq[5] = 32'h4010D193;   // srai x3,x1,1
      seq[6] = 32'h00000013;   // addi x0 (nop)
      seq[7] = 32'h00012303;   // lw x6,0(x2)
      seq[8] = 32'h0060A023;   // sw x6,0(x1) -> rs2 load-use

      rst = 1; if_valid = 0; if_instr = 0; if_pc = 0; stall_in = 0; flush = 0;
      step();
      rst = 0; go = 1;
      #1;
      chk("rst_ex_valid", 32'(ex_valid), 0);
      chk("rst_busy", 32'(muldiv_busy), 0);
      chk("rst_id_ready", 32'(id_ready), 1);
      chk("rst_load_regfile", 32'(ex_ctrl.load_regfile), 0);
      chk("rst_ex_instr", ex_instr, 0);
      chk("rst_byte_en", 32'(ex_ctrl.mem_byte_enable), 32'hF);

      // load-use: exactly one bubble
      if_valid = 1; if_instr = I_LW; if_pc = 32'h100;
      step();
      if_instr = I_ADD; if_pc = 32'h104; #1;
      chk("lu_id_ready_hold", 32'(id_ready), 0);
      chk("lu_lw_rd", 32'(ex_rd), 2);
      step();
      chk("lu_bubble_valid", 32'(ex_valid), 0);
      chk("lu_bubble_ready", 32'(id_ready), 1);
      step();
      chk("lu_add_valid", 32'(ex_valid), 1);
      chk("lu_add_rd", 32'(ex_rd), 3);
      chk("lu_add_aluop", 32'(ex_ctrl.aluop), 32'(alu_add));
      chk("lu_add_pc", ex_pc, 32'h104);

      // MUL hold: two not-ready cycles
      if_instr = I_MUL; if_pc = 32'h200;
      step();
      if_instr = I_ADDI; if_pc = 32'h204; #1;
      chk("mul_busy1", 32'(muldiv_busy), 1);
      chk("mul_ready1", 32'(id_ready), 0);
      chk("mul_rd", 32'(ex_rd), 4);
      chk("mul_en", 32'(ex_ctrl.muldiv_en), 1);
      step();
      chk("mul_ready2", 32'(id_ready), 0);
      chk("mul_pc_hold", ex_pc, 32'h200);
      step();
      chk("mul_ready3", 32'(id_ready), 1);
      chk("mul_busy3", 32'(muldiv_busy), 0);
      step();
      chk("mul_next_pc", ex_pc, 32'h204);

      // DIV with flush on hold cycle 5
      if_instr = I_DIV; if_pc = 32'h300;
      step();
      if_instr = I_ADDI; if_pc = 32'h304;
      repeat (4) step();
      chk("div_busy_pre", 32'(muldiv_busy), 1);
      flush = 1; #1;
      chk("div_flush_ready", 32'(id_ready), 0);
      step();
      flush = 0; #1;
      chk("div_flush_valid", 32'(ex_valid), 0);
      chk("div_flush_busy", 32'(muldiv_busy), 0);
      chk("div_flush_next_ready", 32'(id_ready), 1);
      step();
      chk("div_after_pc", ex_pc, 32'h304);

      // stall freezes; stall+flush -> flush wins
      if_instr = I_DIV; if_pc = 32'h400;
      step();
      stall_in = 1; if_instr = I_ADDI; if_pc = 32'h404;
      repeat (3) step();
      chk("stall_pc", ex_pc, 32'h400);
      chk("stall_busy", 32'(muldiv_busy), 1);
      stall_in = 0;
      repeat (DIV_C - 2) step();
      chk("stall_frozen_busy", 32'(muldiv_busy), 1);
      stall_in = 1; flush = 1;
      step();
      stall_in = 0; flush = 0; #1;
      chk("sf_valid", 32'(ex_valid), 0);
      chk("sf_busy", 32'(muldiv_busy), 0);
      chk("sf_ready", 32'(id_ready), 1);

      // ENABLE_M=0 instance: mul is illegal, no hold
      if_instr = I_MUL; if_pc = 32'h500;
      step();
      if_valid = 0; #1;
      chk("nom_valid", 32'(n_valid), 1);
      chk("nom_illegal", 32'(n_illegal), 1);
      chk("nom_load_regfile", 32'(n_ctrl.load_regfile), 0);
      chk("nom_busy", 32'(n_busy), 0);
      chk("nom_ready", 32'(n_ready), 1);
      chk("m_illegal_lit", 32'(ex_illegal), 0);
      repeat (3) step();

      // mixed directed sequence checked by the model
      for (int s = 0; s < 9; s++) begin
         issue(seq[s], 32'h600 + 32'(s) * 4);
         if (s == 0) begin
            chk("lui_rd", 32'(ex_rd), 1);
            chk("lui_rf_sel", 32'(ex_ctrl.regfilemux_sel), 32'(rf_u_imm));
         end
         if (s == 2) begin
            chk("unk_illegal", 32'(ex_illegal), 1);
            chk("unk_rd", 32'(ex_rd), 0);
         end
         if (s == 4) chk("sra_aluop", 32'(ex_ctrl.aluop), 32'(alu_sra));
         if (s == 6) chk("nop_load_regfile", 32'(ex_ctrl.load_regfile), 0);
         if (s == 8) chk("sw_after_lw_pc", ex_pc, 32'h620);
      end
      if_valid = 0;
      repeat (3) step();

      go = 0;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- RV32I/M instruction-decode pipeline stage: combinational control decode plus the registered ID/EX boundary.
- Extends plain RV32I decode with optional RV32M decode, an internal load-use interlock, and a multi-cycle mul/div hold counter.
- Sits between the IF/ID register and the execute stage.
- Produces a registered control word, PC, instruction and rd for EX, and back-pressures IF through id_ready.

Parameters:
- ENABLE_M, 1, 1 = decode RV32M (funct7 = 0000001 on op_reg); 0 = such encodings flagged illegal.
- MUL_CYCLES, 3, EX occupancy in cycles for mul/mulh/mulhsu/mulhu (>= 1).
- DIV_CYCLES, 33, EX occupancy in cycles for div/divu/rem/remu (>= 1).
- CNT_W, $clog2(DIV_CYCLES+1), hold-counter width (derived; not overridden).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_valid  in  1  IF/ID holds a valid instruction
- if_instr  in  32  instruction word
- if_pc  in  32  instruction PC
- stall_in  in  1  downstream (memory) stall; freezes stage
- flush  in  1  EX redirect; kill ID/EX contents
- id_ready  out  1  stage accepts if_instr this cycle; IF holds when 0
- ex_valid  out  1  ID/EX entry valid
- ex_ctrl  out  rv32i_control_word  registered control word
- ex_pc  out  32  registered PC
- ex_instr  out  32  registered instruction
- ex_rd  out  5  registered destination register
- ex_illegal  out  1  registered illegal-instruction flag (only meaningful with ex_valid)
- muldiv_busy  out  1  hold counter nonzero

Behaviour:
- Reset: ex_valid=0, ex_ctrl = default word, ex_pc=0, ex_instr=0 (not a NOP), ex_rd=0, ex_illegal=0, counter=0.
- Default word: no regfile load, aluop=add, cmpop=beq, all muxes at first selects, mem_byte_enable=4'b1111, muldiv_en=0.
- Decode is combinational from if_instr; it matches the existing RV32I mapping.
  - slt/sltu: compare unit, regfile sel br_en.
  - sr/sub: chosen by funct7[5].
  - jal/jalr: pc_plus4 and alu_mod2.
  - loads: regfile sel by funct3.
- M ops (ENABLE_M=1): muldiv_en=1, muldiv_op=funct3, regfile sel muldiv_out.
- Unknown opcode or unsupported funct7: default word, illegal=1, load_regfile=0.
- rd used only if load_regfile=1; rd=x0 forces load_regfile=0.
- rs1 used by jalr/br/load/store/imm/reg.
- rs2 used by br/store/reg.
- Load-use hazard (comb): all of
  - ex_valid, ex_ctrl.dmem_read, ex_rd!=0;
  - ex_rd equals a used rs1/rs2 of if_instr;
  - if_valid.
- Per-cycle priority, highest first:
  1. rst.
  2. flush: ex_valid<=0, counter<=0; id_ready=0; flush wins over stall_in.
  3. stall_in: all registers and counter hold; id_ready=0.
  4. counter!=0: ID/EX holds, counter decrements; id_ready=0.
  5. load-use: bubble, ex_valid<=0; id_ready=0. Next cycle the hazard is gone and the instruction issues (exactly one bubble).
  6. Normal: ID/EX <= decode, ex_valid<=if_valid; id_ready=1.
- Counter load: on a normal advance of a valid M op, counter <= MUL_CYCLES-1 or DIV_CYCLES-1. With latency 1 there is no hold.
- A flush during a hold clears the counter immediately; the next cycle is normal.
- No combinational path from stall_in/flush to the ID/EX registers other than the enables.
- muldiv_busy = (counter != 0).

Decomposition:
- Additions to rv32i_types:
  - muldiv_funct3_t (mul, mulh, mulhsu, mulhu, div, divu, rem, remu).
  - control-word fields muldiv_en and muldiv_op.
  - regfilemux entry muldiv_out.
  - constant RV32M_FUNCT7 = 7'b0000001.
- Sub-module decode_rom: the combinational decoder with ENABLE_M. Inputs instr; outputs ctrl word, illegal, rs1_used, rs2_used.
- id_stage holds the hazard logic, counter and ID/EX register.

Test Plan:
- Reset then idle: rst 1 cycle, if_valid=0 -> ex_valid=0, muldiv_busy=0, id_ready=1, ex_ctrl.load_regfile=0.
- Load-use: 0x0000A103 (lw x2,0(x1)) then 0x001101B3 (add x3,x2,x1).
  - Cycle after lw issues: id_ready=0, ex_valid=0.
  - Next cycle: add issues, ex_rd=3, aluop=add.
- MUL hold (MUL_CYCLES=3): 0x02108233 (mul x4,x1,x1) issues, then id_ready=0 for exactly 2 cycles, muldiv_busy=1; the third cycle accepts the next instruction.
- DIV with flush: 0x0210C2B3 (div x5,x1,x1), flush on hold cycle 5 -> ex_valid=0, counter=0, next cycle id_ready=1.
- ENABLE_M=0: 0x02108233 -> ex_illegal=1, ex_ctrl.load_regfile=0, no hold.
- stall_in plus flush in the same cycle during a hold -> flush wins. stall_in alone: ex_pc unchanged, counter frozen.
